// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared constants, state codes and helpers for the ALU share arbiter
package alu_arb_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int CTRL_W_DEF = 4;
   localparam int TAG_W_DEF  = 5;

   localparam int P_INT = 0;
   localparam int P_FP  = 1;

   typedef logic [1:0] state_t;
   localparam state_t IDLE  = 2'd0;
   localparam state_t ISSUE = 2'd1;
   localparam state_t RESP  = 2'd2;

   function automatic logic [1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant; rr_last moves only when a grant is taken
module rr_arb2
   import alu_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [1:0] valid,
   output logic [1:0] grant
);

   logic rr_last;

   // A grant is only ever raised toward a valid port, so any grant is a handshake.
   always_comb begin
      grant = 2'b00;
      if (enable) begin
         if (valid[P_INT] && (!valid[P_FP] || rr_last))
            grant[P_INT] = 1'b1;
         else if (valid[P_FP])
            grant[P_FP] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rr_last <= 1'b1;
      else if (|grant)
         rr_last <= grant[P_FP];
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one integer ALU between the INT EX stage and FP-side helpers
// Optional ALU busy-cycle counter enabled by ALU_ARB_UTIL_CNT_EN.
module alu_share_arbiter
   import alu_arb_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int TAG_W  = TAG_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [CTRL_W-1:0] req_ctrl0,
   input  logic [CTRL_W-1:0] req_ctrl1,
   input  logic [XLEN-1:0]   req_a0,
   input  logic [XLEN-1:0]   req_a1,
   input  logic [XLEN-1:0]   req_b0,
   input  logic [XLEN-1:0]   req_b1,
   input  logic [TAG_W-1:0]  req_tag0,
   input  logic [TAG_W-1:0]  req_tag1,
   output logic [CTRL_W-1:0] alu_control,
   output logic [XLEN-1:0]   alu_a,
   output logic [XLEN-1:0]   alu_b,
   input  logic [XLEN-1:0]   alu_result,
   input  logic              alu_zero,
   output logic [1:0]        rsp_valid,
   input  logic [1:0]        rsp_ready,
   output logic [XLEN-1:0]   rsp_data,
   output logic              rsp_zero,
   output logic [TAG_W-1:0]  rsp_tag
`ifdef ALU_ARB_UTIL_CNT_EN
   ,
   output logic [31:0]       busy_cnt
`endif
);

   state_t     state;
   logic       owner;
   logic [1:0] grant;
   logic       handshake;
   logic       rsp_done;

   rr_arb2 u_rr_arb2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (state == IDLE && !flush),
      .valid  (req_valid),
      .grant  (grant)
   );

   assign req_ready = grant;
   assign handshake = |grant;
   assign rsp_valid = (state == RESP) ? port_onehot(owner) : 2'b00;
   assign rsp_done  = (state == RESP) && rsp_ready[owner];

   // ALU operands only load on a handshake so the ALU inputs stay quiet while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         owner       <= 1'b0;
         alu_control <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         rsp_data    <= '0;
         rsp_zero    <= 1'b0;
         rsp_tag     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (handshake) begin
                  state       <= ISSUE;
                  owner       <= grant[P_FP];
                  alu_control <= grant[P_FP] ? req_ctrl1 : req_ctrl0;
                  alu_a       <= grant[P_FP] ? req_a1    : req_a0;
                  alu_b       <= grant[P_FP] ? req_b1    : req_b0;
                  rsp_tag     <= grant[P_FP] ? req_tag1  : req_tag0;
               end
            end
            ISSUE: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  rsp_data <= alu_result;
                  rsp_zero <= alu_zero;
                  state    <= RESP;
               end
            end
            RESP: begin
               if (flush || rsp_done)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_ARB_UTIL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         busy_cnt <= 32'd0;
      else if (state == ISSUE)
         busy_cnt <= busy_cnt + 32'd1;
   end
`endif

endmodule
